// File: rtl/mem_port_arbiter_if.sv
// Bundles the IF fetch port, the D load/store port and the memory control lines
// into one handshake bundle; the arbiter takes the slave view and the
// CPU pipeline plus the memory block together take the master view.
interface mem_port_arbiter_if #(
    parameter int AW = 30,
    parameter int DW = 32
);
    // instruction-fetch port
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          if_flush;

    // load/store data port
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;

    // single-port memory side
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wren;
    logic          mem_rren;
    logic          mem_en;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    // arbiter view
    modport slave (
        input  if_req, if_addr, if_flush,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output if_ack, if_rdata,
        output d_ack, d_rdata,
        output mem_addr, mem_wdata, mem_wren, mem_rren, mem_en,
        output busy
    );

    // requester / memory view
    modport master (
        output if_req, if_addr, if_flush,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  if_ack, if_rdata,
        input  d_ack, d_rdata,
        input  mem_addr, mem_wdata, mem_wren, mem_rren, mem_en,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the IF fetch port and the D load/store port.
// Latency: request sampled in IDLE cycle t -> ack in cycle t+2+MEM_LAT; one access per MEM_LAT+3 cycles.
// Backpressure: requesters hold req until their one-cycle ack; requests are only sampled while IDLE.
module mem_port_arbiter #(
    parameter int AW         = 30,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t        state;
    logic          owner_d;      // 1 = D port owns the current access, 0 = IF
    logic          we_q;
    logic          flushed;      // IF access was flushed while in flight
    logic [LW-1:0] wait_cnt;
    logic [SW-1:0] starve_cnt;

    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          wren_q;
    logic          rren_q;
    logic          en_q;
    logic          if_ack_q;
    logic          d_ack_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;

    logic          if_req_eff;
    logic          starved;
    logic          grant_d;
    logic          grant_if;
    logic          flush_hit;

    // Arbitration: D has priority unless IF has been passed over STARVE_MAX times;
    // a flush in IDLE hides the IF request for that cycle.
    always_comb begin
        if_req_eff = bus.if_req & ~bus.if_flush;
        starved    = (starve_cnt == SW'(STARVE_MAX));
        grant_d    = bus.d_req & ~(if_req_eff & starved);
        grant_if   = if_req_eff & ~grant_d;
        flush_hit  = ~owner_d & (flushed | bus.if_flush);
    end

    // Access sequencer: IDLE -> ISSUE -> WAIT x MEM_LAT -> ACK, all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            owner_d    <= 1'b0;
            we_q       <= 1'b0;
            flushed    <= 1'b0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wren_q     <= 1'b0;
            rren_q     <= 1'b0;
            en_q       <= 1'b0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            // strobes are single-cycle; the state that needs them re-asserts them
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            en_q     <= 1'b0;
            rren_q   <= 1'b0;
            wren_q   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (grant_d || grant_if) begin
                        state   <= S_ISSUE;
                        owner_d <= grant_d;
                        we_q    <= grant_d & bus.d_we;
                        addr_q  <= grant_d ? bus.d_addr : bus.if_addr;
                        if (grant_d) begin
                            wdata_q <= bus.d_wdata;
                        end
                        en_q    <= 1'b1;
                        rren_q  <= ~(grant_d & bus.d_we);
                        wren_q  <= grant_d & bus.d_we;
                        flushed <= 1'b0;
                    end
                    // count D wins while IF is waiting; any IF win or idle IF clears it
                    if (grant_d && if_req_eff) begin
                        if (!starved) begin
                            starve_cnt <= starve_cnt + SW'(1);
                        end
                    end else if (grant_if || !if_req_eff) begin
                        starve_cnt <= '0;
                    end
                end

                S_ISSUE: begin
                    state    <= S_WAIT;
                    wait_cnt <= LW'(MEM_LAT - 1);
                    if (!owner_d && bus.if_flush) begin
                        flushed <= 1'b1;
                    end
                end

                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        // last wait cycle: memory data is valid now
                        if (flush_hit) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_ACK;
                            if (owner_d) begin
                                d_ack_q <= 1'b1;
                                if (!we_q) begin
                                    d_rdata_q <= bus.mem_rdata;
                                end
                            end else begin
                                if_ack_q   <= 1'b1;
                                if_rdata_q <= bus.mem_rdata;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt - LW'(1);
                        if (!owner_d && bus.if_flush) begin
                            flushed <= 1'b1;
                        end
                    end
                end

                S_ACK: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wren  = wren_q;
    assign bus.mem_rren  = rren_q;
    assign bus.mem_en    = en_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state != S_IDLE);

endmodule
